plot_receiver: RTL
==================

Name: plot_receiver

Overview:
- Receiving end of the renderer pixel-plot interface: consumes the (x, y, colour, writeEn) strobe stream the rectangle and other renderers emit.
- Clips each pixel to the 160x120 screen and converts it to a linear framebuffer address.
- Buffers pixels in a small show-ahead FIFO and drains them to the framebuffer memory write port under a ready handshake.
- Sits between all renderers and the VGA framebuffer RAM.

Parameters:
- DEPTH, 8, FIFO entries; power of two, 2..64
- SCREEN_W, 160, visible columns
- SCREEN_H, 120, visible rows

Ports:
- clk  in  1  system clock, rising edge
- resetn  in  1  reset; asynchronous, active-high (asserted = 1) despite the name
- in_x  in  8  pixel column
- in_y  in  7  pixel row
- in_colour  in  3  RGB colour
- in_plot  in  1  pixel strobe, one pixel per cycle high
- in_ready  out  1  FIFO can accept a pixel this cycle
- mem_we  out  1  write request to framebuffer
- mem_addr  out  15  linear address y*160+x
- mem_data  out  3  colour to write
- mem_ready  in  1  framebuffer accepts write this cycle
- overflow  out  1  sticky: a pixel was dropped because FIFO full
- busy  out  1  FIFO non-empty

Behaviour:
- Reset (async, resetn=1): FIFO emptied, read/write pointers 0, overflow=0, mem_we=0, mem_addr=0, mem_data=0, busy=0, in_ready=1 once released. Reset mid-drain discards all queued pixels; no partial write is held.
- Accept: at rising edge with in_plot=1 and in_ready=1, pixel is clipped. Pixel is discarded silently (no FIFO write, no overflow) if in_x>=SCREEN_W or in_y>=SCREEN_H. Otherwise, push {addr, colour}.
- Address: addr = (in_y<<7) + (in_y<<5) + in_x, computed in 15 bits before push; max 19199 (y=119, x=159). No multiplier.
- in_ready = !full, combinational from registered count; a full FIFO refuses a push even if a pop occurs the same cycle.
- Drop: in_plot=1 with in_ready=0 and pixel in range sets overflow=1. Overflow stays set until reset. Out-of-range pixels never set overflow.
- Show-ahead output: mem_we = !empty; mem_addr/mem_data = FIFO head, valid whenever mem_we=1.
- Pop: occurs at rising edge when mem_we=1 and mem_ready=1. mem_addr/mem_data must hold stable while mem_we=1 and mem_ready=0.
- Latency: pixel pushed at edge N appears on mem_* after edge N (mem_we high during cycle N+1) when FIFO was empty; one cycle minimum.
- Simultaneous push and pop (not full): count unchanged, both pointers advance; order preserved strictly FIFO.
- Pointers wrap modulo DEPTH; count is $clog2(DEPTH)+1 bits, full when count==DEPTH, empty when count==0.
- busy = !empty.
- Throughput: one pixel per cycle sustained when mem_ready held high.

Optional Feature:
- Macro PLOT_CLIP_COUNT_EN.
- Defined: extra output clip_count [15:0] counts discarded out-of-range strobes. Counter saturates at 16'hFFFF, resets to 0.
- Undefined: port absent, clipped pixels just vanish; all other behaviour identical.

Decomposition:
- Shared package/header holds SCREEN_W, SCREEN_H, address width 15, colour width 3, and the pixel entry layout {addr[14:0], colour[2:0]} = 18 bits.
- One natural sub-module: plot_fifo, a generic show-ahead synchronous FIFO (width, DEPTH) with push/pop/full/empty/count. Clipping, address math and overflow flag stay in plot_receiver.

Test Plan:
- Reset then in_plot with x=3, y=2, colour=3'b101, mem_ready=1 -> next cycle mem_we=1, mem_addr=323, mem_data=5; following cycle busy=0.
- Plot x=159, y=119 then x=160, y=0, then x=0, y=120 -> only addr 19199 written; overflow=0; clip_count=2 with PLOT_CLIP_COUNT_EN.
- mem_ready=0, 8 in-range plots then 9th -> in_ready=0 after 8th, 9th dropped, overflow=1. Release mem_ready -> 8 writes in push order, one per cycle.
- 4x4 rectangle burst at (10,20) with mem_ready toggling 1,0,1,0 -> 16 writes, addresses 3210..3213, 3370..3373, 3530..3533, 3690..3693, in order, addr stable during stalls.
- Continuous plots with mem_ready=1 for 32 cycles -> count never exceeds 1, no overflow, 32 writes.
- Assert resetn asynchronously with 5 pixels queued -> mem_we drops immediately, busy=0, overflow=0, queued pixels never written.

Source files
------------

// File: rtl/plot_receiver_pkg.sv
// Shared screen geometry, pixel entry layout and address helper for the plot receiver.
package plot_receiver_pkg;

    localparam int SCREEN_W = 160;
    localparam int SCREEN_H = 120;
    localparam int ADDR_W   = 15;
    localparam int COLOUR_W = 3;
    localparam int ENTRY_W  = ADDR_W + COLOUR_W;

    typedef struct packed {
        logic [ADDR_W-1:0]   addr;
        logic [COLOUR_W-1:0] colour;
    } pixel_t;

    // y*160 + x built from shifts: 160 = 128 + 32
    function automatic logic [ADDR_W-1:0] pixel_addr(input logic [7:0] x, input logic [6:0] y);
        return ({8'd0, y} << 7) + ({8'd0, y} << 5) + {7'd0, x};
    endfunction

endpackage

// File: rtl/plot_fifo.sv
// Generic show-ahead synchronous FIFO; head entry is visible on rdata whenever not empty.
module plot_fifo #(
    parameter int WIDTH = 18,
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           wdata,
    output logic [WIDTH-1:0]           rdata,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    // A full FIFO refuses a push even when a pop frees a slot in the same cycle.
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/plot_receiver.sv
// Clips renderer pixel strobes to the screen, queues them and drains them to the framebuffer.
// Optional out-of-range strobe counter enabled by defining PLOT_CLIP_COUNT_EN.
module plot_receiver #(
    parameter int DEPTH    = 8,
    parameter int SCREEN_W = plot_receiver_pkg::SCREEN_W,
    parameter int SCREEN_H = plot_receiver_pkg::SCREEN_H
) (
    input  logic                                  clk,
    input  logic                                  resetn,
    input  logic [7:0]                            in_x,
    input  logic [6:0]                            in_y,
    input  logic [plot_receiver_pkg::COLOUR_W-1:0] in_colour,
    input  logic                                  in_plot,
    output logic                                  in_ready,
    output logic                                  mem_we,
    output logic [plot_receiver_pkg::ADDR_W-1:0]  mem_addr,
    output logic [plot_receiver_pkg::COLOUR_W-1:0] mem_data,
    input  logic                                  mem_ready,
    output logic                                  overflow,
    output logic                                  busy
`ifdef PLOT_CLIP_COUNT_EN
    ,
    output logic [15:0]                           clip_count
`endif
);

    import plot_receiver_pkg::*;

    localparam logic [7:0] X_LIM = 8'(SCREEN_W);
    localparam logic [6:0] Y_LIM = 7'(SCREEN_H);

    pixel_t                   entry;
    pixel_t                   head;
    logic                     in_range;
    logic                     full;
    logic                     empty;
    logic [$clog2(DEPTH):0]   count;

    assign in_range     = (in_x < X_LIM) && (in_y < Y_LIM);
    assign entry.addr   = pixel_addr(in_x, in_y);
    assign entry.colour = in_colour;

    plot_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (resetn),
        .push  (in_plot && in_range),
        .pop   (mem_ready),
        .wdata (entry),
        .rdata (head),
        .full  (full),
        .empty (empty),
        .count (count)
    );

    // Outputs read zero while empty so unreset storage never shows on the write port.
    assign in_ready = !full;
    assign mem_we   = !empty;
    assign mem_addr = empty ? '0 : head.addr;
    assign mem_data = empty ? '0 : head.colour;
    assign busy     = (count != '0);

    always_ff @(posedge clk or posedge resetn) begin
        if (resetn) begin
            overflow <= 1'b0;
        end else if (in_plot && in_range && full) begin
            overflow <= 1'b1;
        end
    end

`ifdef PLOT_CLIP_COUNT_EN
    always_ff @(posedge clk or posedge resetn) begin
        if (resetn) begin
            clip_count <= '0;
        end else if (in_plot && !in_range && (clip_count != 16'hFFFF)) begin
            clip_count <= clip_count + 16'd1;
        end
    end
`endif

endmodule
